// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared encodings for the multicycle control FSM and its decoder
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CL_RTYPE   = 3'd0,
        CL_ADDI    = 3'd1,
        CL_LOAD    = 3'd2,
        CL_STORE   = 3'd3,
        CL_BRANCH  = 3'd4,
        CL_JUMP    = 3'd5,
        CL_ILLEGAL = 3'd6
    } instr_class_t;

    typedef enum logic [1:0] {
        SZ_NONE = 2'd0,
        SZ_BYTE = 2'd1,
        SZ_HALF = 2'd2,
        SZ_WORD = 2'd3
    } access_size_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b101;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // One-hot {byte, halfword, word} enables for an access size.
    function automatic logic [2:0] size_to_en(input access_size_t sz);
        case (sz)
            SZ_BYTE: return 3'b100;
            SZ_HALF: return 3'b010;
            SZ_WORD: return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational opcode/funct decoder: class, ALU control, access size
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [5:0]   i_opcode,
    input  logic [5:0]   i_funct,
    output instr_class_t o_class,
    output logic [2:0]   o_alu_op,
    output logic         o_alu_src,
    output access_size_t o_size,
    output logic         o_illegal
);

    always_comb begin
        o_class   = CL_ILLEGAL;
        o_alu_op  = ALU_ADD;
        o_alu_src = 1'b0;
        o_size    = SZ_NONE;
        case (i_opcode)
            OP_RTYPE: begin
                o_class = CL_RTYPE;
                case (i_funct)
                    FN_ADD:  o_alu_op = ALU_ADD;
                    FN_SUB:  o_alu_op = ALU_SUB;
                    FN_AND:  o_alu_op = ALU_AND;
                    FN_OR:   o_alu_op = ALU_OR;
                    FN_XOR:  o_alu_op = ALU_XOR;
                    FN_SLT:  o_alu_op = ALU_SLT;
                    default: o_class  = CL_ILLEGAL;
                endcase
            end
            OP_ADDI: begin
                o_class   = CL_ADDI;
                o_alu_src = 1'b1;
            end
            OP_LB, OP_LH, OP_LW: begin
                o_class   = CL_LOAD;
                o_alu_src = 1'b1;
                o_size    = (i_opcode == OP_LB) ? SZ_BYTE :
                            (i_opcode == OP_LH) ? SZ_HALF : SZ_WORD;
            end
            OP_SB, OP_SH, OP_SW: begin
                o_class   = CL_STORE;
                o_alu_src = 1'b1;
                o_size    = (i_opcode == OP_SB) ? SZ_BYTE :
                            (i_opcode == OP_SH) ? SZ_HALF : SZ_WORD;
            end
            OP_BEQ, OP_BNE: begin
                o_class  = CL_BRANCH;
                o_alu_op = ALU_SUB;
            end
            OP_J: begin
                o_class = CL_JUMP;
            end
            default: begin
                o_class = CL_ILLEGAL;
            end
        endcase
    end

    assign o_illegal = (o_class == CL_ILLEGAL);

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle CPU control FSM driving datapath strobes
// Optional performance counters are built when CTRL_PERF_CNT_EN is defined.
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX    = 15,
    parameter int HALT_ON_ILLEGAL = 1
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        zero_flag,
    input  logic        mem_ready,
    output logic [2:0]  alu_op,
    output logic        alu_src,
    output logic        branch_taken,
    output logic        jump_taken,
    output logic        pc_write,
    output logic        ir_write,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        mem_read,
    output logic        mem_write,
    output logic        byte_en,
    output logic        halfword_en,
    output logic        word_en,
    output logic        illegal_instr,
    output logic        mem_timeout,
    output logic [2:0]  state_out
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [31:0] retired_count,
    output logic [31:0] cycle_count
`endif
);

    localparam int WAIT_W = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);

    state_t       r_state;
    logic [31:0]  r_ir;
    logic [WAIT_W-1:0] r_wait;

    state_t       w_next;
    instr_class_t w_class;
    logic [2:0]   w_dec_alu_op;
    logic         w_dec_alu_src;
    access_size_t w_size;
    logic         w_illegal;
    logic [2:0]   w_width;
    logic         w_is_nop;
    logic         w_timeout;

    logic [2:0]   w_alu_op;
    logic         w_alu_src;
    logic         w_branch;
    logic         w_jump;
    logic         w_pc_write;
    logic         w_ir_write;
    logic         w_reg_write;
    logic         w_reg_dst;
    logic         w_mem_to_reg;
    logic         w_mem_read;
    logic         w_mem_write;
    logic         w_width_on;
    logic         w_illegal_pulse;

    ctrl_decode u_decode (
        .i_opcode  (r_ir[31:26]),
        .i_funct   (r_ir[5:0]),
        .o_class   (w_class),
        .o_alu_op  (w_dec_alu_op),
        .o_alu_src (w_dec_alu_src),
        .o_size    (w_size),
        .o_illegal (w_illegal)
    );

    assign w_is_nop  = (r_ir == 32'd0);
    assign w_width   = size_to_en(w_size);
    assign w_timeout = (r_state == S_MEM) && (r_wait == WAIT_W'(MEM_WAIT_MAX));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_ir    <= 32'd0;
            r_wait  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_FETCH) begin
                r_ir <= instr;
            end
            // Counter is zero whenever MEM is entered, and is dropped on abort.
            if ((r_state != S_MEM) || w_timeout) begin
                r_wait <= '0;
            end else if (!mem_ready) begin
                r_wait <= r_wait + WAIT_W'(1);
            end
        end
    end

    always_comb begin
        w_next          = r_state;
        w_alu_op        = ALU_ADD;
        w_alu_src       = 1'b0;
        w_branch        = 1'b0;
        w_jump          = 1'b0;
        w_pc_write      = 1'b0;
        w_ir_write      = 1'b0;
        w_reg_write     = 1'b0;
        w_reg_dst       = 1'b0;
        w_mem_to_reg    = 1'b0;
        w_mem_read      = 1'b0;
        w_mem_write     = 1'b0;
        w_width_on      = 1'b0;
        w_illegal_pulse = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_ir_write = 1'b1;
                w_next     = S_DECODE;
            end
            S_DECODE: begin
                if (w_is_nop) begin
                    w_pc_write = 1'b1;
                    w_next     = S_FETCH;
                end else if (w_class == CL_JUMP) begin
                    w_pc_write = 1'b1;
                    w_jump     = 1'b1;
                    w_next     = S_FETCH;
                end else if (w_illegal) begin
                    w_illegal_pulse = 1'b1;
                    if (HALT_ON_ILLEGAL != 0) begin
                        w_next = S_HALT;
                    end else begin
                        w_pc_write = 1'b1;
                        w_next     = S_FETCH;
                    end
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                w_alu_op  = w_dec_alu_op;
                w_alu_src = w_dec_alu_src;
                case (w_class)
                    CL_RTYPE, CL_ADDI:  w_next = S_WB;
                    CL_LOAD, CL_STORE:  w_next = S_MEM;
                    CL_BRANCH: begin
                        w_pc_write = 1'b1;
                        w_branch   = (r_ir[31:26] == OP_BNE) ? ~zero_flag : zero_flag;
                        w_next     = S_FETCH;
                    end
                    default:            w_next = S_FETCH;
                endcase
            end
            S_MEM: begin
                w_mem_read  = (w_class == CL_LOAD);
                w_mem_write = (w_class == CL_STORE);
                w_width_on  = 1'b1;
                if (w_timeout) begin
                    w_pc_write = 1'b1;
                    w_next     = S_FETCH;
                end else if (mem_ready) begin
                    if (w_class == CL_STORE) begin
                        w_pc_write = 1'b1;
                        w_next     = S_FETCH;
                    end else begin
                        w_next = S_WB;
                    end
                end
            end
            S_WB: begin
                w_reg_write = 1'b1;
                w_pc_write  = 1'b1;
                w_reg_dst   = (w_class == CL_RTYPE);
                // Loads keep the read strobe up so read data is still valid at write-back.
                if (w_class == CL_LOAD) begin
                    w_mem_to_reg = 1'b1;
                    w_mem_read   = 1'b1;
                    w_width_on   = 1'b1;
                end
                w_next = S_FETCH;
            end
            S_HALT: begin
                w_next = S_HALT;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    assign alu_op        = reset ? 3'b000 : w_alu_op;
    assign alu_src       = w_alu_src       & ~reset;
    assign branch_taken  = w_branch        & ~reset;
    assign jump_taken    = w_jump          & ~reset;
    assign pc_write      = w_pc_write      & ~reset;
    assign ir_write      = w_ir_write      & ~reset;
    assign reg_write     = w_reg_write     & ~reset;
    assign reg_dst       = w_reg_dst       & ~reset;
    assign mem_to_reg    = w_mem_to_reg    & ~reset;
    assign mem_read      = w_mem_read      & ~reset;
    assign mem_write     = w_mem_write     & ~reset;
    assign byte_en       = w_width_on & w_width[2] & ~reset;
    assign halfword_en   = w_width_on & w_width[1] & ~reset;
    assign word_en       = w_width_on & w_width[0] & ~reset;
    assign illegal_instr = w_illegal_pulse & ~reset;
    assign mem_timeout   = w_timeout       & ~reset;
    assign state_out     = r_state;

`ifdef CTRL_PERF_CNT_EN
    logic [31:0] r_retired;
    logic [31:0] r_cycles;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_retired <= 32'd0;
            r_cycles  <= 32'd0;
        end else begin
            if (w_pc_write && !w_timeout) begin
                r_retired <= r_retired + 32'd1;
            end
            if (r_state != S_HALT) begin
                r_cycles <= r_cycles + 32'd1;
            end
        end
    end

    assign retired_count = r_retired;
    assign cycle_count   = r_cycles;
`endif

endmodule
